// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned DEF_MAX_D_STREAK = 4;
    localparam int unsigned DEF_TIMEOUT      = 255;

    // Read data returned to the owner when the watchdog aborts an access
    localparam logic [DATA_W-1:0] ABORT_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and backing-memory handshake signals of the port arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              IF_Req;
    logic [DATA_W-1:0] IF_Addr;
    logic [DATA_W-1:0] IF_Rdata;
    logic              IF_Ready;
    logic              IF_Stall;

    logic              D_Req;
    logic              D_Write;
    logic [DATA_W-1:0] D_Addr;
    logic [DATA_W-1:0] D_Wdata;
    logic [DATA_W-1:0] D_Rdata;
    logic              D_Ready;
    logic              D_Stall;

    logic              Mem_Req;
    logic              Mem_Write;
    logic [DATA_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Wdata;
    logic              Mem_Ack;
    logic [DATA_W-1:0] Mem_Rdata;
    logic              Mem_Err;

    // Arbiter view
    modport slave (
        input  IF_Req, IF_Addr, D_Req, D_Write, D_Addr, D_Wdata, Mem_Ack, Mem_Rdata,
        output IF_Rdata, IF_Ready, IF_Stall, D_Rdata, D_Ready, D_Stall,
        output Mem_Req, Mem_Write, Mem_Addr, Mem_Wdata, Mem_Err
    );

    // Pipeline stages plus memory view
    modport master (
        output IF_Req, IF_Addr, D_Req, D_Write, D_Addr, D_Wdata, Mem_Ack, Mem_Rdata,
        input  IF_Rdata, IF_Ready, IF_Stall, D_Rdata, D_Ready, D_Stall,
        input  Mem_Req, Mem_Write, Mem_Addr, Mem_Wdata, Mem_Err
    );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle counter; o_expire flags the edge at which the count reaches TIMEOUT.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned    CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // TIMEOUT of 0 disables the watchdog entirely
    assign o_expire = (TIMEOUT != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data ports;
// data has priority, bounded by a fetch anti-starvation streak and a watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic               CLK,
    input  logic               RESET,
    mem_port_arbiter_if.slave  io_bus
);

    localparam int unsigned   SW         = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_e        r_state,     w_state_nxt;
    logic [SW-1:0]     r_streak,    w_streak_nxt;
    logic              r_mem_req,   w_mem_req_nxt;
    logic              r_mem_write, w_mem_write_nxt;
    logic [DATA_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_mem_err,   w_mem_err_nxt;
    logic              r_if_ready,  w_if_ready_nxt;
    logic              r_d_ready,   w_d_ready_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;

    logic w_if_elig, w_d_elig, w_grant_f, w_grant_d;
    logic w_wd_clear, w_wd_enable, w_wd_expire;

    // A port pulsing Ready still holds its old request this cycle, so it is skipped
    assign w_if_elig   = io_bus.IF_Req & ~r_if_ready;
    assign w_d_elig    = io_bus.D_Req  & ~r_d_ready;
    assign w_grant_f   = (r_state == IDLE) & w_if_elig & (~w_d_elig | (r_streak == STREAK_MAX));
    assign w_grant_d   = (r_state == IDLE) & w_d_elig & ~w_grant_f;
    assign w_wd_clear  = w_grant_f | w_grant_d;
    assign w_wd_enable = (r_state != IDLE) & ~io_bus.Mem_Ack;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (CLK),
        .i_rst_n  (RESET),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_wd_expire)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_err   <= 1'b0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_streak    <= w_streak_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_err   <= w_mem_err_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_d_ready   <= w_d_ready_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_streak_nxt    = r_streak;
        w_mem_req_nxt   = r_mem_req;
        w_mem_write_nxt = r_mem_write;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_err_nxt   = 1'b0;
        w_if_ready_nxt  = 1'b0;
        w_d_ready_nxt   = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;

        case (r_state)
            IDLE: begin
                if (!io_bus.IF_Req) begin
                    w_streak_nxt = '0;
                end
                if (w_grant_f) begin
                    w_state_nxt     = F_BUSY;
                    w_streak_nxt    = '0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_write_nxt = 1'b0;
                    w_mem_addr_nxt  = io_bus.IF_Addr;
                    w_mem_wdata_nxt = '0;
                end else if (w_grant_d) begin
                    w_state_nxt     = D_BUSY;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_write_nxt = io_bus.D_Write;
                    w_mem_addr_nxt  = io_bus.D_Addr;
                    w_mem_wdata_nxt = io_bus.D_Wdata;
                    if (io_bus.IF_Req && (r_streak != STREAK_MAX)) begin
                        w_streak_nxt = r_streak + 1'b1;
                    end
                end
            end
            F_BUSY, D_BUSY: begin
                // Ack wins over a simultaneous watchdog expiry (expire is gated by ~Ack)
                if (io_bus.Mem_Ack || w_wd_expire) begin
                    w_state_nxt     = IDLE;
                    w_mem_req_nxt   = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_mem_err_nxt   = ~io_bus.Mem_Ack;
                    if (r_state == F_BUSY) begin
                        w_if_ready_nxt = 1'b1;
                        w_if_rdata_nxt = io_bus.Mem_Ack ? io_bus.Mem_Rdata : ABORT_DATA;
                    end else begin
                        w_d_ready_nxt = 1'b1;
                        if (!io_bus.Mem_Ack) begin
                            w_d_rdata_nxt = ABORT_DATA;
                        end else if (!r_mem_write) begin
                            w_d_rdata_nxt = io_bus.Mem_Rdata;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign io_bus.Mem_Req   = r_mem_req;
    assign io_bus.Mem_Write = r_mem_write;
    assign io_bus.Mem_Addr  = r_mem_addr;
    assign io_bus.Mem_Wdata = r_mem_wdata;
    assign io_bus.Mem_Err   = r_mem_err;
    assign io_bus.IF_Ready  = r_if_ready;
    assign io_bus.IF_Rdata  = r_if_rdata;
    assign io_bus.D_Ready   = r_d_ready;
    assign io_bus.D_Rdata   = r_d_rdata;
    // Stalls are combinational; forced low while reset is held
    assign io_bus.IF_Stall  = RESET & io_bus.IF_Req & ~r_if_ready;
    assign io_bus.D_Stall   = RESET & io_bus.D_Req  & ~r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed stimulus for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned MAXS = 4;
    localparam int unsigned TMO  = 8;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_D_STREAK (MAXS),
        .TIMEOUT      (TMO)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .io_bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the memory, how long it has waited, expected outputs
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int unsigned m_age, m_lat, m_streak;
    logic        e_req, e_wr, e_if_rdy, e_d_rdy, e_err;
    logic [31:0] e_addr, e_wdata, e_if_rd, e_d_rd;

    int unsigned next_lat  = 0;
    bit          use_fixed = 0;
    logic [31:0] rd_fixed  = '0;
    bit          loads_only = 0;
    bit          if_fin = 0, d_fin = 0;

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_lat = 0; m_streak = 0;
        e_req = 0; e_wr = 0; e_if_rdy = 0; e_d_rdy = 0; e_err = 0;
        e_addr = '0; e_wdata = '0; e_if_rd = '0; e_d_rd = '0;
    endtask

    task automatic model_edge();
        bit f_ok, d_ok;
        f_ok = bus.IF_Req && !e_if_rdy;
        d_ok = bus.D_Req && !e_d_rdy;
        e_if_rdy = 0; e_d_rdy = 0; e_err = 0;
        if (m_owner == 0) begin
            if (f_ok && (!d_ok || m_streak == MAXS)) begin
                m_owner = 1; m_streak = 0;
                e_req = 1; e_wr = 0; e_addr = bus.IF_Addr;
            end else if (d_ok) begin
                m_owner = 2;
                m_streak = bus.IF_Req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                e_req = 1; e_wr = bus.D_Write; e_addr = bus.D_Addr; e_wdata = bus.D_Wdata;
            end else if (!bus.IF_Req) begin
                m_streak = 0;
            end
            if (m_owner != 0) begin
                m_age = 0;
                m_lat = (next_lat != 0) ? next_lat : $urandom_range(1, 10);
            end
        end else begin
            m_age++;
            if (bus.Mem_Ack || m_age == TMO) begin
                if (m_owner == 1) begin
                    e_if_rdy = 1;
                    e_if_rd  = bus.Mem_Ack ? bus.Mem_Rdata : 32'h0;
                end else begin
                    e_d_rdy = 1;
                    if (!bus.Mem_Ack) e_d_rd = 32'h0;
                    else if (!e_wr)   e_d_rd = bus.Mem_Rdata;
                end
                e_err = !bus.Mem_Ack;
                e_req = 0; e_wr = 0; m_owner = 0;
            end
        end
    endtask

    task automatic check_regs();
        chk("mem_req",   32'(bus.Mem_Req),   32'(e_req));
        chk("mem_write", 32'(bus.Mem_Write), 32'(e_wr));
        if (e_req)         chk("mem_addr",  bus.Mem_Addr,  e_addr);
        if (e_req && e_wr) chk("mem_wdata", bus.Mem_Wdata, e_wdata);
        chk("if_ready", 32'(bus.IF_Ready), 32'(e_if_rdy));
        chk("d_ready",  32'(bus.D_Ready),  32'(e_d_rdy));
        chk("if_rdata", bus.IF_Rdata, e_if_rd);
        chk("d_rdata",  bus.D_Rdata,  e_d_rd);
        chk("mem_err",  32'(bus.Mem_Err), 32'(e_err));
    endtask

    task automatic drive_if(input bit allow);
        if (e_if_rdy) begin
            if_fin = 1;
        end else begin
            if (if_fin) begin bus.IF_Req = 0; if_fin = 0; end
            if (!bus.IF_Req && allow && $urandom_range(0, 2) != 0) begin
                bus.IF_Req  = 1;
                bus.IF_Addr = $urandom & 32'hFFFF_FFFC;
            end
        end
    endtask

    task automatic drive_d(input bit allow);
        if (e_d_rdy) begin
            d_fin = 1;
        end else begin
            if (d_fin) begin bus.D_Req = 0; d_fin = 0; end
            if (!bus.D_Req && allow && $urandom_range(0, 3) != 0) begin
                bus.D_Req   = 1;
                bus.D_Write = loads_only ? 1'b0 : 1'($urandom_range(0, 1));
                bus.D_Addr  = $urandom & 32'hFFFF_FFFC;
                bus.D_Wdata = $urandom;
            end
        end
    endtask

    task automatic step(input bit allow_if, input bit allow_d);
        @(posedge CLK);
        model_edge();
        #1;
        check_regs();
        drive_if(allow_if);
        drive_d(allow_d);
        bus.Mem_Ack   = (m_owner != 0) ? (m_age + 1 == m_lat) : ($urandom_range(0, 3) == 0);
        bus.Mem_Rdata = use_fixed ? rd_fixed : $urandom;
        #1;
        chk("if_stall", 32'(bus.IF_Stall), 32'(bus.IF_Req & ~e_if_rdy));
        chk("d_stall",  32'(bus.D_Stall),  32'(bus.D_Req & ~e_d_rdy));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (bus.IF_Req || bus.D_Req || m_owner != 0 || e_if_rdy || e_d_rdy); i++)
            step(0, 0);
        chk("drain_idle", 32'(bus.IF_Req | bus.D_Req | bus.Mem_Req), 32'h0);
    endtask

    initial begin
        bus.IF_Req = 0; bus.IF_Addr = '0; bus.D_Req = 0; bus.D_Write = 0;
        bus.D_Addr = '0; bus.D_Wdata = '0; bus.Mem_Ack = 0; bus.Mem_Rdata = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_mem_req", 32'(bus.Mem_Req), 32'h0);
        chk("rst_if_rdy",  32'(bus.IF_Ready), 32'h0);
        chk("rst_d_rdata", bus.D_Rdata, 32'h0);
        chk("rst_err",     32'(bus.Mem_Err), 32'h0);
        @(negedge CLK);
        RESET = 1;

        // Fetch alone, ack one cycle after request
        next_lat = 1; use_fixed = 1; rd_fixed = 32'h2008_0005;
        bus.IF_Req = 1; bus.IF_Addr = 32'h0000_0040;
        step(0, 0);
        chk("t1_addr",  bus.Mem_Addr, 32'h40);
        chk("t1_write", 32'(bus.Mem_Write), 32'h0);
        step(0, 0);
        chk("t1_ready", 32'(bus.IF_Ready), 32'h1);
        chk("t1_rdata", bus.IF_Rdata, 32'h2008_0005);
        chk("t1_stall", 32'(bus.IF_Stall), 32'h0);
        step(0, 0);
        chk("t1_nogrant", 32'(bus.Mem_Req), 32'h0);
        use_fixed = 0;
        drain();

        // Simultaneous store and fetch: data first, fetch after D_Ready
        next_lat = 2;
        bus.D_Req = 1; bus.D_Write = 1; bus.D_Addr = 32'h100; bus.D_Wdata = 32'hDEAD_BEEF;
        bus.IF_Req = 1; bus.IF_Addr = 32'h80;
        step(0, 0);
        chk("t2_write", 32'(bus.Mem_Write), 32'h1);
        chk("t2_addr",  bus.Mem_Addr, 32'h100);
        chk("t2_wdata", bus.Mem_Wdata, 32'hDEAD_BEEF);
        repeat (3) step(0, 0);
        chk("t2_f_req",  32'(bus.Mem_Req), 32'h1);
        chk("t2_f_addr", bus.Mem_Addr, 32'h80);
        drain();

        // Fetch held while data streams loads
        next_lat = 1; loads_only = 1;
        bus.IF_Req = 1; bus.IF_Addr = 32'h300;
        repeat (30) step(1, 1);
        loads_only = 0;
        drain();

        // No ack: watchdog aborts TMO cycles after the grant
        next_lat = 100;
        bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 32'h400;
        step(0, 0);
        repeat (TMO - 1) step(0, 0);
        chk("t4_busy", 32'(bus.Mem_Req), 32'h1);
        step(0, 0);
        chk("t4_req",   32'(bus.Mem_Req), 32'h0);
        chk("t4_err",   32'(bus.Mem_Err), 32'h1);
        chk("t4_ready", 32'(bus.D_Ready), 32'h1);
        chk("t4_rdata", bus.D_Rdata, 32'h0);
        drain();

        // Ack in the exact cycle the watchdog would expire
        next_lat = TMO; use_fixed = 1; rd_fixed = 32'hCAFE_F00D;
        bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 32'h500;
        step(0, 0);
        repeat (TMO) step(0, 0);
        chk("t5_ready", 32'(bus.D_Ready), 32'h1);
        chk("t5_err",   32'(bus.Mem_Err), 32'h0);
        chk("t5_rdata", bus.D_Rdata, 32'hCAFE_F00D);
        use_fixed = 0;
        drain();

        // Asynchronous reset in the middle of a data access
        next_lat = 100;
        bus.D_Req = 1; bus.D_Write = 1; bus.D_Addr = 32'h600; bus.D_Wdata = 32'h1234_5678;
        repeat (3) step(0, 0);
        @(negedge CLK);
        #1 RESET = 0;
        #1;
        chk("t6_req",    32'(bus.Mem_Req), 32'h0);
        chk("t6_write",  32'(bus.Mem_Write), 32'h0);
        chk("t6_ready",  32'({bus.IF_Ready, bus.D_Ready}), 32'h0);
        chk("t6_rdata",  bus.IF_Rdata | bus.D_Rdata, 32'h0);
        chk("t6_dstall", 32'(bus.D_Stall), 32'h0);
        bus.D_Req = 0; bus.IF_Req = 1; bus.IF_Addr = 32'h700; bus.Mem_Ack = 0;
        if_fin = 0; d_fin = 0;
        model_reset();
        #1 RESET = 1;
        next_lat = 0;
        step(0, 0);
        chk("t6_grant", 32'(bus.Mem_Req), 32'h1);
        chk("t6_addr",  bus.Mem_Addr, 32'h700);
        drain();

        // Random traffic on both ports
        next_lat = 0;
        repeat (4000) step(1, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
